// File: rtl/line_streamer_if.sv
// line_streamer_if: start/pointer request, memory read port and character stream of line_streamer.
// LINE_STREAMER_REVERSE_EN adds the reverse request bit.
interface line_streamer_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int CHAR_W = 8
);
    logic                    start;
    logic [LEN_W+ADDR_W-1:0] pointer_addr;
`ifdef LINE_STREAMER_REVERSE_EN
    logic                    reverse;
`endif
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_en;
    logic [2*CHAR_W-1:0]     mem_dout;
    logic                    out_valid;
    logic                    out_ready;
    logic [CHAR_W-1:0]       lhs;
    logic [CHAR_W-1:0]       rhs;
    logic                    out_last;
    logic                    busy;
    logic                    done;
    logic [LEN_W-1:0]        chars_remaining;

    modport master (
`ifdef LINE_STREAMER_REVERSE_EN
        output reverse,
`endif
        output start, pointer_addr, mem_dout, out_ready,
        input  mem_addr, mem_en, out_valid, lhs, rhs, out_last, busy, done, chars_remaining
    );

    modport slave (
`ifdef LINE_STREAMER_REVERSE_EN
        input  reverse,
`endif
        input  start, pointer_addr, mem_dout, out_ready,
        output mem_addr, mem_en, out_valid, lhs, rhs, out_last, busy, done, chars_remaining
    );
endinterface

// File: rtl/line_streamer.sv
// line_streamer: fetches one memory word per character of a line and streams {lhs, rhs} with backpressure.
// LINE_STREAMER_REVERSE_EN enables descending reads selected by the reverse bit.
module line_streamer #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int CHAR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    line_streamer_if.slave bus
);
    localparam int D  = MEM_LAT + 1;
    localparam int PW = (D > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ZERO} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, base, first;
    logic [LEN_W-1:0]    len_q, issued_q, issued_d, rem_q, rem_d, len_in;
    logic                dir_q, dir, rev_in, done_q, done_d;
    logic [MEM_LAT-1:0]  vld_q;
    logic [2*CHAR_W-1:0] fifo_q [D];
    logic [PW-1:0]       wr_q, rd_q;
    logic [2:0]          cnt_q, inflight;
    logic [3:0]          occ;
    logic                accept_start, issue, push, pop, last_acc;

`ifdef LINE_STREAMER_REVERSE_EN
    assign rev_in = bus.reverse;
`else
    assign rev_in = 1'b0;
`endif

    assign base         = bus.pointer_addr[ADDR_W-1:0];
    assign len_in       = bus.pointer_addr[LEN_W+ADDR_W-1:ADDR_W];
    assign first        = rev_in ? base + ADDR_W'(len_in) - ADDR_W'(1) : base;
    assign accept_start = (state_q == IDLE) && bus.start;
    assign push         = vld_q[MEM_LAT-1];
    assign pop          = bus.out_valid && bus.out_ready;
    assign last_acc     = pop && bus.out_last;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) inflight = inflight + 3'(vld_q[i]);
    end

    // Occupancy counts the word leaving this cycle as already gone, so a full pipe still streams at one per cycle.
    assign occ      = 4'(cnt_q) + 4'(inflight) - 4'(pop);
    assign issue    = accept_start ? (len_in != '0)
                                   : (state_q == FETCH) && (issued_q != len_q) && (occ < 4'(D));
    assign dir      = accept_start ? rev_in : dir_q;
    assign issued_d = accept_start ? LEN_W'(issue) : issued_q + LEN_W'(issue);
    assign addr_d   = issue ? (dir ? bus.mem_addr - ADDR_W'(1) : bus.mem_addr + ADDR_W'(1)) : addr_q;
    assign rem_d    = accept_start ? len_in : rem_q - LEN_W'(pop);
    assign done_d   = last_acc || (accept_start && len_in == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (len_in != '0) ? FETCH : ZERO;
            FETCH:   if (issued_d == len_q) state_d = DRAIN;
            DRAIN:   if (last_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '1;
            len_q    <= '0;
            issued_q <= '0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            vld_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < D; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            rem_q    <= rem_d;
            dir_q    <= dir;
            done_q   <= done_d;
            vld_q    <= MEM_LAT'({vld_q, issue});
            cnt_q    <= cnt_q + 3'(push) - 3'(pop);
            if (accept_start) len_q <= len_in;
            if (push) fifo_q[wr_q] <= bus.mem_dout;
            if (push) wr_q <= (wr_q == PW'(D - 1)) ? '0 : wr_q + PW'(1);
            if (pop) rd_q <= (rd_q == PW'(D - 1)) ? '0 : rd_q + PW'(1);
        end
    end

    assign bus.mem_en          = issue;
    assign bus.mem_addr        = accept_start ? first : addr_q;
    assign bus.out_valid       = cnt_q != '0;
    assign bus.lhs             = fifo_q[rd_q][2*CHAR_W-1:CHAR_W];
    assign bus.rhs             = fifo_q[rd_q][CHAR_W-1:0];
    assign bus.out_last        = bus.out_valid && (rem_q == LEN_W'(1));
    assign bus.busy            = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.done            = done_q;
    assign bus.chars_remaining = rem_q;
endmodule

// File: tb/tb_line_streamer.sv
// tb_line_streamer: directed checks of two line_streamer instances (MEM_LAT 1 and 3) sharing one stimulus.
// Memory word at address a is {a[7:0], ~a[7:0]}; idle return cycles carry a poison word.
module tb_line_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, ready = 1'b1, sel = 1'b0, rev = 1'b0;
    logic [19:0] ptr = '0;

    line_streamer_if #(.ADDR_W(10), .LEN_W(10), .CHAR_W(8)) b1 ();
    line_streamer_if #(.ADDR_W(10), .LEN_W(10), .CHAR_W(8)) b3 ();

    assign b1.start = start;
    assign b1.pointer_addr = ptr;
    assign b1.out_ready = ready;
    assign b3.start = start;
    assign b3.pointer_addr = ptr;
    assign b3.out_ready = ready;
`ifdef LINE_STREAMER_REVERSE_EN
    assign b1.reverse = rev;
    assign b3.reverse = rev;
`endif

    line_streamer #(.ADDR_W(10), .LEN_W(10), .CHAR_W(8), .MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    line_streamer #(.ADDR_W(10), .LEN_W(10), .CHAR_W(8), .MEM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    logic [15:0] m1;
    logic [15:0] m3 [3];
    always @(posedge clk) begin
        m1    <= b1.mem_en ? {b1.mem_addr[7:0], ~b1.mem_addr[7:0]} : 16'hBAD0;
        m3[0] <= b3.mem_en ? {b3.mem_addr[7:0], ~b3.mem_addr[7:0]} : 16'hBAD0;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign b1.mem_dout = m1;
    assign b3.mem_dout = m3[2];

    logic [9:0] o_addr, o_rem;
    logic [7:0] o_lhs, o_rhs;
    logic       o_en, o_ov, o_last, o_busy, o_done;
    always_comb begin
        o_addr = sel ? b3.mem_addr : b1.mem_addr;
        o_rem  = sel ? b3.chars_remaining : b1.chars_remaining;
        o_lhs  = sel ? b3.lhs : b1.lhs;
        o_rhs  = sel ? b3.rhs : b1.rhs;
        o_en   = sel ? b3.mem_en : b1.mem_en;
        o_ov   = sel ? b3.out_valid : b1.out_valid;
        o_last = sel ? b3.out_last : b1.out_last;
        o_busy = sel ? b3.busy : b1.busy;
        o_done = sel ? b3.done : b1.done;
    end

    int          n_cmp = 0, n_bad = 0;
    int          k_cnt, n_done, first_ov, done_k, n_iss, n_acc, n_ov;
    logic [9:0]  en_q [$];
    logic [16:0] beat_q [$];
    logic [9:0]  s_addr, s_rem;
    logic [7:0]  s_lhs, s_rhs;
    logic        s_en, s_ov, s_last, s_busy, s_done;
    logic        p_ov, p_rdy;
    logic [16:0] p_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        en_q.delete();
        beat_q.delete();
        k_cnt = 0;
        n_done = 0;
        first_ov = -1;
        done_k = -1;
        n_iss = 0;
        n_acc = 0;
        n_ov = 0;
        p_ov = 1'b0;
    endtask

    // Samples the selected DUT mid-cycle, records reads/beats, checks stall holding and return headroom.
    task automatic tick();
        int lat;
        lat = sel ? 3 : 1;
        @(negedge clk);
        #1;
        {s_addr, s_rem, s_lhs, s_rhs} = {o_addr, o_rem, o_lhs, o_rhs};
        {s_en, s_ov, s_last, s_busy, s_done} = {o_en, o_ov, o_last, o_busy, o_done};
        if (p_ov && !p_rdy) chk("hold", {s_ov, s_last, s_lhs, s_rhs}, {1'b1, p_out});
        if (s_en) begin
            chk("room", 32'((n_iss - n_acc - ((s_ov && ready) ? 1 : 0)) <= lat), 32'd1);
            en_q.push_back(s_addr);
            n_iss++;
        end
        if (s_ov) begin
            n_ov++;
            if (first_ov < 0) first_ov = k_cnt;
        end
        if (s_ov && ready) begin
            beat_q.push_back({s_last, s_lhs, s_rhs});
            n_acc++;
        end
        if (s_done) begin
            n_done++;
            done_k = k_cnt;
        end
        p_ov = s_ov;
        p_rdy = ready;
        p_out = {s_last, s_lhs, s_rhs};
        k_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic run(input logic [9:0] base, input logic [9:0] len, input bit bp, input int restart);
        clear();
        ptr = {len, base};
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 120 && n_done == 0; k++) begin
            ready = bp ? (k % 3 == 0) : 1'b1;
            start = restart >= 0 && (beat_q.size() == restart || beat_q.size() == int'(len) - 1);
            if (start) ptr = {10'd2, 10'h200};
            tick();
        end
        start = 1'b0;
        chk("done seen", n_done, 1);
    endtask

    task automatic chk_reset(input string t);
        chk({t, " addr"}, s_addr, 10'h3FF);
        chk({t, " en"}, s_en, 0);
        chk({t, " valid"}, s_ov, 0);
        chk({t, " last"}, s_last, 0);
        chk({t, " busy"}, s_busy, 0);
        chk({t, " done"}, s_done, 0);
        chk({t, " rem"}, s_rem, 0);
        chk({t, " lhs"}, s_lhs, 0);
        chk({t, " rhs"}, s_rhs, 0);
    endtask

    // {mem_en, out_valid, out_last, busy, done, chars_remaining[3:0]} per cycle from the start cycle
    logic [8:0] t1 [8] = '{9'h100, 9'h124, 9'h1A4, 9'h1A3, 9'h0A2, 9'h0E1, 9'h010, 9'h000};

    initial begin
        logic [7:0] e;
        logic [9:0] a;
        clear();
        rst = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk_reset("post reset");

        sel = 1'b0;
        clear();
        ptr = {10'd4, 10'h010};
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            start = (k == 0);
            tick();
            chk("t1 ctl", {s_en, s_ov, s_last, s_busy, s_done, s_rem[3:0]}, t1[k]);
            if (k < 4) chk("t1 addr", s_addr, 32'h010 + k);
            e = 8'(8'h0E + k);
            if (k >= 2 && k < 6) chk("t1 data", {s_lhs, s_rhs}, {e, ~e});
        end
        idle(6);

        sel = 1'b1;
        idle(2);
        run(10'h100, 10'd6, 1'b1, -1);
        chk("t2 beats", beat_q.size(), 6);
        chk("t2 reads", en_q.size(), 6);
        chk("t2 latency", first_ov, 4);
        for (int i = 0; i < beat_q.size(); i++) begin
            e = 8'(i);
            chk("t2 beat", beat_q[i], {i == 5, e, ~e});
        end
        for (int i = 0; i < en_q.size(); i++) chk("t2 addr", en_q[i], 32'h100 + i);
        idle(8);

        sel = 1'b0;
        idle(2);
        run(10'h3FE, 10'd3, 1'b0, -1);
        chk("t3 beats", beat_q.size(), 3);
        chk("t3 latency", first_ov, 2);
        for (int i = 0; i < en_q.size(); i++) begin
            a = 10'(10'h3FE + i);
            chk("t3 addr", en_q[i], a);
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            a = 10'(10'h3FE + i);
            chk("t3 beat", beat_q[i], {i == 2, a[7:0], ~a[7:0]});
        end
        idle(3);

        run(10'h000, 10'd0, 1'b0, -1);
        chk("t4 reads", n_iss, 0);
        chk("t4 valid", n_ov, 0);
        chk("t4 done cycle", done_k, 1);
        tick();
        chk("t4 busy", s_busy, 0);
        chk("t4 done pulse", s_done, 0);
        idle(3);

        run(10'h040, 10'd5, 1'b0, 1);
        chk("t5 beats", beat_q.size(), 5);
        chk("t5 reads", en_q.size(), 5);
        for (int i = 0; i < beat_q.size(); i++) begin
            e = 8'(8'h40 + i);
            chk("t5 beat", beat_q[i], {i == 4, e, ~e});
        end
        for (int i = 0; i < en_q.size(); i++) chk("t5 addr", en_q[i], 32'h040 + i);
        tick();
        chk("t5 busy after", s_busy, 0);
        chk("t5 no restart", s_en, 0);
        chk("t5 rem", s_rem, 0);
        idle(3);

        clear();
        ptr = {10'd5, 10'h080};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && beat_q.size() < 2; k++) tick();
        chk("t6 pre-abort beats", beat_q.size(), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_done = 0;
        tick();
        chk_reset("abort");
        idle(5);
        chk("abort no done", n_done, 0);

`ifdef LINE_STREAMER_REVERSE_EN
        rev = 1'b1;
        run(10'h020, 10'd3, 1'b0, -1);
        rev = 1'b0;
        chk("rev beats", beat_q.size(), 3);
        for (int i = 0; i < en_q.size(); i++) chk("rev addr", en_q[i], 32'h022 - i);
        for (int i = 0; i < beat_q.size(); i++) begin
            e = 8'(8'h22 - i);
            chk("rev beat", beat_q[i], {i == 2, e, ~e});
        end
        idle(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/line_streamer.md
Name: line_streamer

Overview:
- Parametrised successor to the display-line transformer.
- On a start pulse, latches a packed pointer (line start address and line length) and issues one memory read per character.
- Absorbs a fixed memory read latency and streams each {lhs, rhs} character pair out over a valid/ready handshake with full backpressure.
- Sits between the line-pointer table and the character printer/UART serialiser.

Parameters:
- ADDR_W, 10, character-memory address width.
- LEN_W, 10, line-length field width; max line length is 2^LEN_W-1.
- CHAR_W, 8, width of one character; memory word is 2*CHAR_W.
- MEM_LAT, 1, memory read latency in cycles (mem_en at cycle t -> mem_dout valid at t+MEM_LAT); legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- pointer_addr  in  LEN_W+ADDR_W  [ADDR_W-1:0] = line start, [LEN_W+ADDR_W-1:ADDR_W] = line length
- mem_addr  out  ADDR_W  read address
- mem_en  out  1  read strobe; one read per high cycle
- mem_dout  in  2*CHAR_W  read data, [2*CHAR_W-1:CHAR_W] = lhs, low half = rhs
- out_valid  out  1  lhs/rhs/out_last valid
- out_ready  in  1  consumer accepts when out_valid&out_ready
- lhs  out  CHAR_W  input-side character
- rhs  out  CHAR_W  transformed character
- out_last  out  1  high on the final character of the line
- busy  out  1  high from accepted start until the last beat is accepted
- done  out  1  one-cycle pulse after the last beat is accepted (or after a zero-length start)
- chars_remaining  out  LEN_W  characters not yet accepted by the consumer

Behaviour:
- Synchronous active-high reset, single clock domain (clk).
- Reset values:
  - mem_addr = all ones; mem_en = 0
  - out_valid, out_last, busy, done = 0
  - chars_remaining = 0
  - lhs, rhs = 0
  - internal FIFO emptied, in-flight count = 0, state = IDLE
- States:
  - IDLE: start=1 latches base and len; chars_remaining <= len; busy <= 1. Next state is FETCH if len!=0, else ZERO.
  - ZERO: done=1 for one cycle, busy=0, then IDLE. No mem_en and no out_valid in this path.
  - FETCH: issues reads at base, base+1, ... Moves to DRAIN after len reads have been issued.
  - DRAIN: no further reads. When the out_last beat is accepted: done=1 for one cycle, busy=0, then IDLE.
- Read issue rule:
  - mem_en=1 only when issued_count < len AND (fifo_count + inflight) < MEM_LAT+1.
  - This guarantees no returned word is ever dropped under backpressure.
  - mem_addr increments after each issued read, modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0 is legal and required).
- Return path:
  - A delay line of depth MEM_LAT tags valid returns.
  - A tagged word is written into a MEM_LAT+1 deep FIFO.
  - lhs/rhs are driven from the FIFO head (registered); out_valid = FIFO non-empty.
- Throughput and latency:
  - With out_ready held high, one character per cycle.
  - First out_valid appears MEM_LAT+1 cycles after the start cycle.
- Output handshake:
  - out_valid, lhs, rhs and out_last hold stable while out_valid & !out_ready.
  - chars_remaining decrements on each accepted beat.
  - out_last = (chars_remaining==1) & out_valid.
- start while busy: ignored; no re-latch and no effect on the stream in progress.
- rst mid-line: aborts immediately. In-flight returns are discarded and no done pulse is produced.
- Simultaneous final-beat accept and new start in the same cycle: start is ignored (still busy that cycle).

Optional Feature:
- Macro: LINE_STREAMER_REVERSE_EN.
- Defined: adds input port `reverse` (1 bit), sampled with start.
  - reverse=1: reads go base+len-1 down to base, decrementing modulo 2^ADDR_W.
  - out_last still marks the final emitted beat.
  - reverse=0: identical to the non-reverse build.
- Undefined: no `reverse` port; addresses always ascend.

Test Plan:
- MEM_LAT=1, base=0x010, len=4, out_ready=1:
  - mem_addr 0x010..0x013 on consecutive cycles.
  - 4 beats with out_last on the 4th.
  - done one cycle after the 4th accept; chars_remaining 4->0.
- MEM_LAT=3, len=6, out_ready toggled 1,0,0,1,...:
  - All 6 words delivered in order, none lost or duplicated.
  - mem_en never asserted while fifo_count+inflight==4.
  - Held outputs stable during stalls.
- base=0x3FE, len=3:
  - mem_addr sequence 0x3FE, 0x3FF, 0x000.
  - Data matches the memory model.
- len=0 start:
  - done pulse on the next cycle; no mem_en, no out_valid; busy low afterwards.
- start pulsed mid-stream (len=5, pulsed at beat 2):
  - Ignored, stream completes unchanged.
  - rst asserted at beat 3: all outputs return to reset values the next cycle, no done pulse.
- LINE_STREAMER_REVERSE_EN defined, reverse=1, base=0x020, len=3:
  - mem_addr 0x022, 0x021, 0x020; out_last on the beat from 0x020.
